// File: rtl/scoreboard_pkg.sv
// Shared types, segment constants and BCD helpers for the N-team scoreboard.
package scoreboard_pkg;

    localparam int SCORE_W = 17;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {A,B,C,D,E,F,G,DP}; DP is always off (bit 0 high).
    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
        8'h49, 8'h41, 8'h1F, 8'h01, 8'h09
    };

    // Per-team button events, packed so a {clear, dec, inc} vector casts straight in.
    typedef struct packed {
        logic clr;
        logic dec;
        logic inc;
    } btn_evt_t;

    function automatic logic [7:0] seg_decode(input logic [3:0] value);
        logic [7:0] seg;
        seg = SEG_BLANK;
        if (value < 4'd10) begin
            seg = SEG_DIGIT[value];
        end
        return seg;
    endfunction

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    // Only ever called with a constant idx, so each call folds to constant dividers.
    function automatic logic [3:0] bcd_digit(input logic [SCORE_W-1:0] score,
                                             input int unsigned idx);
        logic [SCORE_W-1:0] q;
        q = score;
        for (int unsigned i = 0; i < idx; i++) begin
            q = q / SCORE_W'(10);
        end
        return 4'(q % SCORE_W'(10));
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw button conditioner: 2-flop synchroniser, stable-count debounce and
// rising-edge pulse on the debounced level.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic level,
    output logic pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             level_d1_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg    <= 1'b0;
            sync2_reg    <= 1'b0;
            level_reg    <= 1'b0;
            level_d1_reg <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            sync1_reg    <= btn;
            sync2_reg    <= sync1_reg;
            level_d1_reg <= level_reg;
            // Any return to the accepted level restarts qualification.
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                level_reg <= sync2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign pulse = level_reg & ~level_d1_reg;

endmodule

// File: rtl/scoreboard_mux_n.sv
// N-team, D-digit saturating scoreboard driving one time-multiplexed 7-segment bus.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits of each team.
module scoreboard_mux_n
    import scoreboard_pkg::*;
#(
    parameter int NUM_TEAMS       = 2,
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int SCAN_DIV_W      = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_TEAMS-1:0]           btn_inc,
    input  logic [NUM_TEAMS-1:0]           btn_dec,
    input  logic [NUM_TEAMS-1:0]           btn_clear,
    input  logic [2:0]                     inc_adjust,
    output logic [7:0]                     seg_out,
    output logic [NUM_TEAMS*NUM_DIGITS-1:0] digit_en,
    output logic [NUM_TEAMS*SCORE_W-1:0]   score_bin
);

    localparam int NUM_SLOTS = NUM_TEAMS * NUM_DIGITS;
    localparam int IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [SCORE_W:0] MAX_SCORE = (SCORE_W+1)'(pow10(NUM_DIGITS) - 1);

    logic [NUM_SLOTS*8-1:0] slot_seg;

    genvar gi, gk, gd;
    generate
        for (gi = 0; gi < NUM_TEAMS; gi++) begin : g_team
            logic [2:0]         raw_btn;
            logic [2:0]         pulse_vec;
            logic [2:0]         btn_level_unused;
            btn_evt_t           evt;
            logic [SCORE_W-1:0] score_reg;
            logic [SCORE_W-1:0] score_next;
            logic [SCORE_W:0]   score_ext;
            logic [SCORE_W:0]   step;
            logic [SCORE_W:0]   sum;
            logic [SCORE_W:0]   diff;

            assign raw_btn = {btn_clear[gi], btn_dec[gi], btn_inc[gi]};

            for (gk = 0; gk < 3; gk++) begin : g_btn
                button_debounce #(
                    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
                ) u_debounce (
                    .clk    (clk),
                    .reset_n(reset_n),
                    .btn    (raw_btn[gk]),
                    .level  (btn_level_unused[gk]),
                    .pulse  (pulse_vec[gk])
                );
            end

            assign evt = btn_evt_t'(pulse_vec);

            // One spare bit of headroom lets inc/dec compare before truncating.
            always_comb begin
                score_ext  = {1'b0, score_reg};
                step       = {{(SCORE_W-2){1'b0}}, inc_adjust} + (SCORE_W+1)'(1);
                sum        = score_ext + step;
                diff       = score_ext - step;
                score_next = score_reg;
                if (evt.clr) begin
                    score_next = '0;
                end else if (evt.inc && evt.dec) begin
                    score_next = score_reg;
                end else if (evt.inc) begin
                    score_next = (sum > MAX_SCORE) ? MAX_SCORE[SCORE_W-1:0] : sum[SCORE_W-1:0];
                end else if (evt.dec) begin
                    score_next = (score_ext < step) ? '0 : diff[SCORE_W-1:0];
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    score_reg <= '0;
                end else begin
                    score_reg <= score_next;
                end
            end

            assign score_bin[gi*SCORE_W +: SCORE_W] = score_reg;

            for (gd = 0; gd < NUM_DIGITS; gd++) begin : g_digit
                logic [3:0] bcd;
                logic [7:0] seg;

                assign bcd = bcd_digit(score_reg, gd);
`ifdef LEADING_ZERO_BLANK_EN
                if (gd == 0) begin : g_ones
                    assign seg = seg_decode(bcd);
                end else begin : g_upper
                    // Every digit at or above gd is zero exactly when score < 10**gd.
                    assign seg = ({1'b0, score_reg} < (SCORE_W+1)'(pow10(gd)))
                                 ? SEG_BLANK : seg_decode(bcd);
                end
`else
                assign seg = seg_decode(bcd);
`endif
                assign slot_seg[(gi*NUM_DIGITS + gd)*8 +: 8] = seg;
            end
        end
    endgenerate

    logic [SCAN_DIV_W-1:0] div_reg;
    logic [IDX_W-1:0]      scan_idx_reg;
    logic [IDX_W-1:0]      scan_idx_next;
    logic                  scan_tick;
    logic [7:0]            seg_reg;
    logic [7:0]            seg_next;
    logic [NUM_SLOTS-1:0]  digit_en_reg;
    logic [NUM_SLOTS-1:0]  digit_en_next;

    assign scan_tick = &div_reg;

    always_comb begin
        scan_idx_next = scan_idx_reg + 1'b1;
        if (scan_idx_reg == IDX_W'(NUM_SLOTS - 1)) begin
            scan_idx_next = '0;
        end
        seg_next      = slot_seg[int'(scan_idx_reg)*8 +: 8];
        digit_en_next = ~(NUM_SLOTS'(1) << scan_idx_reg);
    end

    // Segments and selects load on the same tick so the display never shows a mismatched pair.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_reg      <= '0;
            scan_idx_reg <= '0;
            seg_reg      <= SEG_BLANK;
            digit_en_reg <= '1;
        end else begin
            div_reg <= div_reg + 1'b1;
            if (scan_tick) begin
                scan_idx_reg <= scan_idx_next;
                seg_reg      <= seg_next;
                digit_en_reg <= digit_en_next;
            end
        end
    end

    assign seg_out  = seg_reg;
    assign digit_en = digit_en_reg;

endmodule

// File: tb/tb_scoreboard_mux_n.sv
// Directed self-checking bench for scoreboard_mux_n (2 teams, 4 digits, fast debounce/scan).
module tb_scoreboard_mux_n;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  btn_inc;
    logic [1:0]  btn_dec;
    logic [1:0]  btn_clear;
    logic [2:0]  inc_adjust;
    logic [7:0]  seg_out;
    logic [7:0]  digit_en;
    logic [33:0] score_bin;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] seg_of [10];
    logic [7:0] lz_seg;

    scoreboard_mux_n #(
        .NUM_TEAMS      (2),
        .NUM_DIGITS     (4),
        .DEBOUNCE_CYCLES(4),
        .SCAN_DIV_W     (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_inc   (btn_inc),
        .btn_dec   (btn_dec),
        .btn_clear (btn_clear),
        .inc_adjust(inc_adjust),
        .seg_out   (seg_out),
        .digit_en  (digit_en),
        .score_bin (score_bin)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Hold the given raw buttons long enough to qualify, then release and let them settle.
    task automatic press(input logic [1:0] inc_m, input logic [1:0] dec_m,
                         input logic [1:0] clr_m, input logic [2:0] adj);
        inc_adjust = adj;
        btn_inc    = inc_m;
        btn_dec    = dec_m;
        btn_clear  = clr_m;
        repeat (8) @(posedge clk);
        @(negedge clk);
        btn_inc   = 2'b00;
        btn_dec   = 2'b00;
        btn_clear = 2'b00;
        repeat (8) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        btn_inc    = 2'b00;
        btn_dec    = 2'b00;
        btn_clear  = 2'b00;
        inc_adjust = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (seg_out !== 8'hFF) begin
            tests_failed++;
            $display("FAIL reset_seg: got %h expected %h", seg_out, 8'hFF);
        end
        tests_run++;
        if (digit_en !== 8'hFF) begin
            tests_failed++;
            $display("FAIL reset_digit_en: got %b expected %b", digit_en, 8'hFF);
        end
        tests_run++;
        if (score_bin !== 34'd0) begin
            tests_failed++;
            $display("FAIL reset_score: got %h expected 0", score_bin);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (digit_en !== 8'hFF || seg_out !== 8'hFF) begin
            tests_failed++;
            $display("FAIL reset_release_display: got en=%b seg=%h expected en=11111111 seg=ff",
                     digit_en, seg_out);
        end
        @(negedge clk);
        $display("[TB] test_reset done");
    endtask

    task automatic test_latency();
        logic [16:0] exp_score;
        inc_adjust = 3'b010;
        btn_inc    = 2'b01;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk);
            #1;
            exp_score = (e == 7) ? 17'd3 : 17'd0;
            tests_run++;
            if (score_bin[16:0] !== exp_score) begin
                tests_failed++;
                $display("FAIL latency_edge%0d: score0 got %0d expected %0d",
                         e, score_bin[16:0], exp_score);
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        btn_inc = 2'b00;
        repeat (8) @(posedge clk);
        #1;
        tests_run++;
        if (score_bin[16:0] !== 17'd3 || score_bin[33:17] !== 17'd0) begin
            tests_failed++;
            $display("FAIL latency_hold: got s0=%0d s1=%0d expected s0=3 s1=0",
                     score_bin[16:0], score_bin[33:17]);
        end
        @(negedge clk);
        btn_inc = 2'b10;
        repeat (3) @(posedge clk);
        @(negedge clk);
        btn_inc = 2'b00;
        repeat (10) @(posedge clk);
        #1;
        tests_run++;
        if (score_bin[33:17] !== 17'd0) begin
            tests_failed++;
            $display("FAIL glitch_ignored: score1 got %0d expected 0", score_bin[33:17]);
        end
        @(negedge clk);
        $display("[TB] test_latency done");
    endtask

    task automatic test_saturate();
        press(2'b00, 2'b00, 2'b01, 3'b000);
        for (int i = 0; i < 1249; i++) begin
            press(2'b01, 2'b00, 2'b00, 3'b111);
        end
        press(2'b01, 2'b00, 2'b00, 3'b010);
        tests_run++;
        if (score_bin[16:0] !== 17'd9995) begin
            tests_failed++;
            $display("FAIL sat_build: score0 got %0d expected 9995", score_bin[16:0]);
        end
        press(2'b01, 2'b00, 2'b00, 3'b111);
        tests_run++;
        if (score_bin[16:0] !== 17'd9999) begin
            tests_failed++;
            $display("FAIL sat_top: score0 got %0d expected 9999", score_bin[16:0]);
        end
        press(2'b01, 2'b00, 2'b00, 3'b000);
        tests_run++;
        if (score_bin[16:0] !== 17'd9999) begin
            tests_failed++;
            $display("FAIL sat_hold: score0 got %0d expected 9999", score_bin[16:0]);
        end
        press(2'b00, 2'b00, 2'b01, 3'b000);
        press(2'b01, 2'b00, 2'b00, 3'b100);
        tests_run++;
        if (score_bin[16:0] !== 17'd5) begin
            tests_failed++;
            $display("FAIL step5: score0 got %0d expected 5", score_bin[16:0]);
        end
        press(2'b00, 2'b01, 2'b00, 3'b111);
        tests_run++;
        if (score_bin[16:0] !== 17'd0) begin
            tests_failed++;
            $display("FAIL floor: score0 got %0d expected 0", score_bin[16:0]);
        end
        press(2'b00, 2'b01, 2'b00, 3'b000);
        tests_run++;
        if (score_bin[16:0] !== 17'd0) begin
            tests_failed++;
            $display("FAIL floor_hold: score0 got %0d expected 0", score_bin[16:0]);
        end
        $display("[TB] test_saturate done");
    endtask

    task automatic test_priority();
        press(2'b01, 2'b00, 2'b00, 3'b100);
        press(2'b01, 2'b01, 2'b00, 3'b000);
        tests_run++;
        if (score_bin[16:0] !== 17'd5) begin
            tests_failed++;
            $display("FAIL inc_dec_cancel: score0 got %0d expected 5", score_bin[16:0]);
        end
        press(2'b11, 2'b00, 2'b01, 3'b000);
        tests_run++;
        if (score_bin[16:0] !== 17'd0) begin
            tests_failed++;
            $display("FAIL clear_wins: score0 got %0d expected 0", score_bin[16:0]);
        end
        tests_run++;
        if (score_bin[33:17] !== 17'd1) begin
            tests_failed++;
            $display("FAIL team_indep: score1 got %0d expected 1", score_bin[33:17]);
        end
        $display("[TB] test_priority done");
    endtask

    task automatic test_scan();
        logic [7:0] exp_seg [8];
        logic [7:0] prev_en;
        logic [7:0] last_en;
        logic [7:0] last_seg;
        logic [7:0] exp_en;
        logic       found;
        press(2'b00, 2'b00, 2'b11, 3'b000);
        for (int i = 0; i < 5; i++) press(2'b11, 2'b00, 2'b00, 3'b111);
        for (int i = 0; i < 158; i++) press(2'b10, 2'b00, 2'b00, 3'b111);
        press(2'b10, 2'b00, 2'b00, 3'b010);
        press(2'b01, 2'b00, 2'b00, 3'b001);
        tests_run++;
        if (score_bin[16:0] !== 17'd42 || score_bin[33:17] !== 17'd1307) begin
            tests_failed++;
            $display("FAIL scan_setup: got s0=%0d s1=%0d expected s0=42 s1=1307",
                     score_bin[16:0], score_bin[33:17]);
        end
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 0) begin
                exp_seg = '{seg_of[2], seg_of[4], lz_seg, lz_seg,
                            seg_of[7], seg_of[0], seg_of[3], seg_of[1]};
            end else begin
                press(2'b00, 2'b00, 2'b01, 3'b000);
                exp_seg = '{seg_of[0], lz_seg, lz_seg, lz_seg,
                            seg_of[7], seg_of[0], seg_of[3], seg_of[1]};
            end
            found   = 1'b0;
            prev_en = digit_en;
            for (int c = 0; c < 64 && !found; c++) begin
                @(posedge clk);
                #1;
                if (digit_en == 8'hFE && prev_en != 8'hFE) found = 1'b1;
                else prev_en = digit_en;
            end
            tests_run++;
            if (!found) begin
                tests_failed++;
                $display("FAIL scan_sync phase%0d: digit 0 select never appeared, en=%b",
                         ph, digit_en);
            end else begin
                tests_run++;
                if (seg_out !== exp_seg[0]) begin
                    tests_failed++;
                    $display("FAIL scan_seg phase%0d slot0: got %h expected %h",
                             ph, seg_out, exp_seg[0]);
                end
                for (int k = 1; k <= 8; k++) begin
                    last_en  = digit_en;
                    last_seg = seg_out;
                    for (int c = 1; c <= 3; c++) begin
                        @(posedge clk);
                        #1;
                        tests_run++;
                        if (digit_en !== last_en || seg_out !== last_seg) begin
                            tests_failed++;
                            $display("FAIL scan_hold phase%0d step%0d: got en=%b seg=%h expected en=%b seg=%h",
                                     ph, k, digit_en, seg_out, last_en, last_seg);
                        end
                    end
                    @(posedge clk);
                    #1;
                    exp_en = ~(8'd1 << (k % 8));
                    tests_run++;
                    if (digit_en !== exp_en) begin
                        tests_failed++;
                        $display("FAIL scan_en phase%0d step%0d: got %b expected %b",
                                 ph, k, digit_en, exp_en);
                    end
                    tests_run++;
                    if (seg_out !== exp_seg[k % 8]) begin
                        tests_failed++;
                        $display("FAIL scan_seg phase%0d slot%0d: got %h expected %h",
                                 ph, k % 8, seg_out, exp_seg[k % 8]);
                    end
                end
                @(negedge clk);
            end
        end
        $display("[TB] test_scan done");
    endtask

    task automatic test_reset_mid();
        logic [16:0] exp_score;
        btn_clear = 2'b01;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (seg_out !== 8'hFF || digit_en !== 8'hFF) begin
            tests_failed++;
            $display("FAIL midreset_display: got seg=%h en=%b expected seg=ff en=11111111",
                     seg_out, digit_en);
        end
        tests_run++;
        if (score_bin !== 34'd0) begin
            tests_failed++;
            $display("FAIL midreset_score: got %h expected 0", score_bin);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        btn_clear  = 2'b00;
        repeat (10) @(posedge clk);
        @(negedge clk);
        inc_adjust = 3'b000;
        btn_inc    = 2'b01;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk);
            #1;
            exp_score = (e == 7) ? 17'd1 : 17'd0;
            tests_run++;
            if (score_bin[16:0] !== exp_score) begin
                tests_failed++;
                $display("FAIL requalify_edge%0d: score0 got %0d expected %0d",
                         e, score_bin[16:0], exp_score);
            end
        end
        @(negedge clk);
        btn_inc = 2'b00;
        repeat (8) @(posedge clk);
        @(negedge clk);
        $display("[TB] test_reset_mid done");
    endtask

    initial begin
        seg_of = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
`ifdef LEADING_ZERO_BLANK_EN
        lz_seg = 8'hFF;
`else
        lz_seg = 8'h03;
`endif
        reset_n    = 1'b0;
        btn_inc    = 2'b00;
        btn_dec    = 2'b00;
        btn_clear  = 2'b00;
        inc_adjust = 3'b000;
        @(negedge clk);
        test_reset();
        test_latency();
        test_saturate();
        test_priority();
        test_scan();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
